// File: rtl/pll_reset_seq.sv
// PLL reset/lock sequencer: POR hold, PLL reset pulses with timeout retry, ordered periph/cpu release.
// Latency: pll_locked reaches locked_s after 2 cycles; all outputs registered with the state; no backpressure.
module pll_reset_seq #(
  parameter int POR_CYCLES         = 1024,
  parameter int PLL_RST_CYCLES     = 16,
  parameter int LOCK_TIMEOUT       = 1048576,
  parameter int LOCK_STABLE_CYCLES = 4096,
  parameter int RELEASE_GAP        = 64,
  parameter int MAX_RETRIES        = 7
) (
  input  logic       refclk,
  input  logic       rst_n,
  input  logic       pll_locked,
  input  logic       restart_req,
  output logic       pll_rst,
  output logic       periph_reset,
  output logic       cpu_reset,
  output logic       ready,
  output logic       restart_ack,
  output logic       fault,
  output logic [2:0] retry_count,
  output logic [2:0] state
);

  typedef enum logic [2:0] {
    ST_POR        = 3'd0,
    ST_PLL_RST    = 3'd1,
    ST_WAIT_LOCK  = 3'd2,
    ST_STABLE     = 3'd3,
    ST_REL_PERIPH = 3'd4,
    ST_RUN        = 3'd5,
    ST_FAULT      = 3'd6
  } state_e;

  localparam int CNT_W = $clog2(POR_CYCLES + PLL_RST_CYCLES + LOCK_TIMEOUT +
                                LOCK_STABLE_CYCLES + RELEASE_GAP + 1);

  // Terminal counts: a state lasting N cycles exits when the counter reads N-1.
  localparam logic [CNT_W-1:0] POR_LAST    = CNT_W'(POR_CYCLES - 1);
  localparam logic [CNT_W-1:0] PLL_LAST    = CNT_W'(PLL_RST_CYCLES - 1);
  localparam logic [CNT_W-1:0] TIMEOUT_LAST = CNT_W'(LOCK_TIMEOUT - 1);
  localparam logic [CNT_W-1:0] STABLE_LAST = CNT_W'(LOCK_STABLE_CYCLES - 1);
  localparam logic [CNT_W-1:0] GAP_LAST    = CNT_W'(RELEASE_GAP - 1);
  localparam logic [2:0]       RETRY_MAX   = 3'(MAX_RETRIES);

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [2:0]       retry_q, retry_d;
  logic             sync_meta_q, sync_meta_d;
  logic             locked_s_q, locked_s_d;
  logic             pll_rst_q, pll_rst_d;
  logic             periph_reset_q, periph_reset_d;
  logic             cpu_reset_q, cpu_reset_d;
  logic             ready_q, ready_d;
  logic             restart_ack_q, restart_ack_d;
  logic             fault_q, fault_d;

  always_ff @(posedge refclk or negedge rst_n) begin
    if (!rst_n) begin
      state_q        <= ST_POR;
      cnt_q          <= '0;
      retry_q        <= '0;
      sync_meta_q    <= 1'b0;
      locked_s_q     <= 1'b0;
      pll_rst_q      <= 1'b1;
      periph_reset_q <= 1'b1;
      cpu_reset_q    <= 1'b1;
      ready_q        <= 1'b0;
      restart_ack_q  <= 1'b0;
      fault_q        <= 1'b0;
    end else begin
      state_q        <= state_d;
      cnt_q          <= cnt_d;
      retry_q        <= retry_d;
      sync_meta_q    <= sync_meta_d;
      locked_s_q     <= locked_s_d;
      pll_rst_q      <= pll_rst_d;
      periph_reset_q <= periph_reset_d;
      cpu_reset_q    <= cpu_reset_d;
      ready_q        <= ready_d;
      restart_ack_q  <= restart_ack_d;
      fault_q        <= fault_d;
    end
  end

  always_comb begin
    sync_meta_d   = pll_locked;
    locked_s_d    = sync_meta_q;
    state_d       = state_q;
    retry_d       = retry_q;
    restart_ack_d = 1'b0;

    unique case (state_q)
      ST_POR: begin
        if (cnt_q == POR_LAST) state_d = ST_PLL_RST;
      end
      ST_PLL_RST: begin
        if (cnt_q == PLL_LAST) state_d = ST_WAIT_LOCK;
      end
      ST_WAIT_LOCK: begin
        if (locked_s_q) begin
          state_d = ST_STABLE;
        end else if (cnt_q == TIMEOUT_LAST) begin
          if (retry_q == RETRY_MAX) begin
            state_d = ST_FAULT;
          end else begin
            retry_d = retry_q + 3'd1;
            state_d = ST_PLL_RST;
          end
        end
      end
      ST_STABLE: begin
        // A dropout only restarts the wait; it is not counted as a retry.
        if (!locked_s_q) state_d = ST_WAIT_LOCK;
        else if (cnt_q == STABLE_LAST) state_d = ST_REL_PERIPH;
      end
      ST_REL_PERIPH: begin
        if (!locked_s_q) begin
          state_d = ST_PLL_RST;
        end else if (cnt_q == GAP_LAST) begin
          state_d = ST_RUN;
          retry_d = '0;
        end
      end
      ST_RUN: begin
        // Restart has priority over lock loss so the requester always sees an ack.
        if (restart_req) begin
          state_d       = ST_PLL_RST;
          restart_ack_d = 1'b1;
        end else if (!locked_s_q) begin
          state_d = ST_PLL_RST;
        end
      end
      ST_FAULT: begin
        if (restart_req) begin
          state_d       = ST_PLL_RST;
          restart_ack_d = 1'b1;
          retry_d       = '0;
        end
      end
      default: state_d = ST_POR;
    endcase

    if ((state_d != state_q) || (state_q == ST_RUN) || (state_q == ST_FAULT)) begin
      cnt_d = '0;
    end else begin
      cnt_d = cnt_q + CNT_W'(1);
    end

    // Outputs decode the next state so they change on the same edge as state.
    pll_rst_d      = (state_d == ST_POR) || (state_d == ST_PLL_RST) || (state_d == ST_FAULT);
    periph_reset_d = !((state_d == ST_REL_PERIPH) || (state_d == ST_RUN));
    cpu_reset_d    = (state_d != ST_RUN);
    ready_d        = (state_d == ST_RUN);
    fault_d        = (state_d == ST_FAULT);
  end

  assign pll_rst      = pll_rst_q;
  assign periph_reset = periph_reset_q;
  assign cpu_reset    = cpu_reset_q;
  assign ready        = ready_q;
  assign restart_ack  = restart_ack_q;
  assign fault        = fault_q;
  assign retry_count  = retry_q;
  assign state        = state_q;

endmodule

// File: doc/pll_reset_seq.md
# pll_reset_seq

PLL reset and lock sequencer for the system clock PLL: 50 MHz reference in; 57.27, 28.64 and 14.32 MHz out. It runs on the always-present reference clock. It holds the PLL in reset after power-on and monitors lock, retrying on timeout. Once lock has been stable it releases the peripheral/video reset, then the CPU reset, in order, and it re-sequences on lock loss or on a restart request (for example, from the OSD).

## Interface
Parameters:
- POR_CYCLES, 1024: power-on hold before the first PLL reset pulse
- PLL_RST_CYCLES, 16: width of each pll_rst pulse
- LOCK_TIMEOUT, 1048576: cycles allowed in WAIT_LOCK before a retry
- LOCK_STABLE_CYCLES, 4096: continuous synchronized lock required before release
- RELEASE_GAP, 64: cycles between periph_reset release and cpu_reset release
- MAX_RETRIES, 7: timeouts tolerated before FAULT (retry_count width 3)

Ports:
- refclk  in  1  50 MHz reference clock; the only clock
- rst_n  in  1  asynchronous, active-low reset
- pll_locked  in  1  PLL locked; asynchronous to refclk
- restart_req  in  1  level request to re-sequence the PLL; held until restart_ack
- pll_rst  out  1  active-high reset to the PLL
- periph_reset  out  1  active-high reset for video/peripheral logic
- cpu_reset  out  1  active-high reset for CPU logic
- ready  out  1  high only in RUN
- restart_ack  out  1  one-cycle pulse when restart_req is accepted
- fault  out  1  high in FAULT
- retry_count  out  3  timeouts since the last successful lock
- state  out  3  debug encoding: POR=0, PLL_RST=1, WAIT_LOCK=2, STABLE=3, REL_PERIPH=4, RUN=5, FAULT=6

## Operation
- pll_locked passes through a 2-flop synchronizer (locked_s). restart_req is used directly; the source is in the refclk domain.
- Reset values: pll_rst=1, periph_reset=1, cpu_reset=1, ready=0, restart_ack=0, fault=0, retry_count=0, state=POR, all counters 0.
- Outputs are registered and decoded from the state:
  - pll_rst=1 in POR and PLL_RST.
  - periph_reset=0 only in REL_PERIPH and RUN.
  - cpu_reset=0 only in RUN.
- One counter serves all states. It clears on every state transition.

State transitions:
- **POR**: after POR_CYCLES cycles, go to PLL_RST.
- **PLL_RST**: after PLL_RST_CYCLES cycles, go to WAIT_LOCK.
- **WAIT_LOCK**:
  - locked_s=1: go to STABLE.
  - Counter reaches LOCK_TIMEOUT with retry_count==MAX_RETRIES: go to FAULT.
  - Counter reaches LOCK_TIMEOUT otherwise: retry_count+1, go to PLL_RST.
- **STABLE**:
  - locked_s=0: go to WAIT_LOCK with the counter cleared and no retry increment.
  - After LOCK_STABLE_CYCLES consecutive cycles of locked_s=1: go to REL_PERIPH.
- **REL_PERIPH**:
  - locked_s=0: go to PLL_RST.
  - After RELEASE_GAP cycles: go to RUN and clear retry_count.
- **RUN**:
  - restart_req=1: pulse restart_ack and go to PLL_RST.
  - Otherwise locked_s=0: go to PLL_RST; retry_count is unchanged.
- **FAULT**: fault=1 and all resets are held. The only exits are restart_req (with restart_ack, retry_count cleared, go to PLL_RST) or rst_n.

restart_req in any state other than RUN or FAULT is not latched. It is serviced once RUN or FAULT is reached, if still high.

## Timing
- Latency from pll_locked to locked_s is 2 cycles.
- POR exit: pll_rst falls on edge POR_CYCLES+PLL_RST_CYCLES after rst_n deasserts.
- Release after lock: periph_reset falls 2+LOCK_STABLE_CYCLES edges after the first edge sampling pll_locked=1.
- cpu_reset falls, and ready rises, RELEASE_GAP edges after periph_reset falls.
- Lock loss in REL_PERIPH or RUN:
  - periph_reset, cpu_reset and pll_rst assert, and ready drops, 3 edges after pll_locked falls (2 edges synchronizer, 1 edge state register).
  - pll_rst is then held for PLL_RST_CYCLES.
- restart_ack is high for exactly the cycle in which state first reads PLL_RST.
- Simultaneous restart_req and lock loss in RUN: the restart wins and ack is issued.
- A lock glitch shorter than 1 cycle may be missed. Any glitch seen by locked_s in STABLE restarts the stability count.
- rst_n assertion mid-sequence immediately forces all reset values, asynchronously.

## Test plan
Bench parameters: POR=8, PLL_RST=4, TIMEOUT=64, STABLE=16, GAP=4, MAX_RETRIES=2.

- **Nominal boot**: rst_n high at t0, pll_locked high at edge 20 → pll_rst falls at edge 12; periph_reset falls at edge 38; cpu_reset falls and ready rises at edge 42; retry_count=0.
- **Lock glitch in STABLE**: pll_locked low for 3 cycles at edge 30, high again at edge 33 → state returns to WAIT_LOCK, re-enters STABLE at edge 35, periph_reset falls at edge 51, retry_count=0.
- **Timeouts to FAULT**: pll_locked held at 0:
  - exactly 3 pll_rst pulses, with retry_count going 0→1→2;
  - the third timeout enters FAULT with fault=1 and all resets high;
  - restart_req=1 gives a single restart_ack pulse, fault=0 and retry_count=0.
- **Lock loss in RUN**: drop pll_locked → resets and pll_rst high 3 edges later, ready=0, pll_rst held for 4 cycles; reassert lock → full release sequence repeats.
- **Restart handshake**: assert restart_req in WAIT_LOCK → no ack until RUN, then a 1-cycle ack and state=PLL_RST. Additional case: restart_req plus lock loss on the same edge → exactly one ack.
- **Async reset**: pulse rst_n low mid-REL_PERIPH, off a clock edge → all outputs return to their reset values before the next edge, and the sequence restarts from POR.
